// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
//   Bundles the push side (CPU/bus), the pop side (UART TX FSM) and the
//   status/error signals of the UART transmit byte FIFO.
//
//   Parameters:
//     DW  data width in bits
//     AW  log2(FIFO depth); occupancy is AW+1 bits wide
//
//   Signals (direction as seen by the FIFO, modport slave):
//     flush_i        in   synchronous clear of contents
//     wr_en_i        in   push request
//     wr_data_i      in   push data
//     full_o         out  level == DEPTH
//     almost_full_o  out  level >= almost-full threshold
//     rd_en_i        in   pop request from the TX FSM
//     rd_data_o      out  popped byte, registered and held
//     empty_o        out  level == 0
//     level_o        out  current occupancy, 0..DEPTH
//     overflow_o     out  sticky: push attempted while full
//     underflow_o    out  sticky: pop attempted while empty
//     err_clr_i      in   clears the sticky error flags
//
//   Modports:
//     master  the user side (CPU/bus pusher plus TX FSM popper)
//     slave   the FIFO itself
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          flush_i;
  logic          wr_en_i;
  logic [DW-1:0] wr_data_i;
  logic          full_o;
  logic          almost_full_o;
  logic          rd_en_i;
  logic [DW-1:0] rd_data_o;
  logic          empty_o;
  logic [AW:0]   level_o;
  logic          overflow_o;
  logic          underflow_o;
  logic          err_clr_i;

  modport master (
    output flush_i, wr_en_i, wr_data_i, rd_en_i, err_clr_i,
    input  full_o, almost_full_o, rd_data_o, empty_o, level_o,
           overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, wr_en_i, wr_data_i, rd_en_i, err_clr_i,
    output full_o, almost_full_o, rd_data_o, empty_o, level_o,
           overflow_o, underflow_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO between the CPU/bus and the UART transmit state machine.
//   The bus pushes bytes; the TX FSM pops one byte per frame. Popped data is
//   registered and held until the next accepted pop so the FSM can sample it
//   for a whole frame. No fall-through and no pass-through: a push into an
//   empty FIFO is only visible to a pop on a later cycle.
//
//   Ports:
//     clk   single clock, rising edge
//     rst   asynchronous reset, active-high
//     bus   uart_tx_fifo_if.slave (push/pop handshake, status, error flags)
//
//   Parameters:
//     DW        data width
//     DEPTH     entries, power of two, >= 4
//     AW        log2(DEPTH); pointers carry one extra wrap bit
//     AF_LEVEL  almost_full_o threshold, 1..DEPTH-1
//
//   Configuration macro:
//     UART_TX_FIFO_ERR_EN  when defined, overflow_o/underflow_o are sticky
//                          error flags cleared by err_clr_i (set wins over
//                          clear). When undefined they are tied low and
//                          err_clr_i is ignored.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DW       = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_fifo_if.slave    bus
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] AF_THR  = (AW+1)'(AF_LEVEL);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full;
  logic          push_ok;
  logic          pop_ok;
  logic [DW-1:0] rd_data;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Status comes only from registered pointers, so wr_en_i/rd_en_i never
  // reach an output combinationally.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

  // Acceptance uses the pre-edge state: full+push+pop drops the push,
  // empty+push+pop ignores the pop.
  assign push_ok = bus.wr_en_i && !full;
  assign pop_ok  = bus.rd_en_i && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; contents are meaningless until
  // written and resetting it would turn a RAM into a flop bank.
  always_ff @(posedge clk) begin
    if (push_ok && !bus.flush_i) mem[wr_idx] <= bus.wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (pop_ok && !bus.flush_i) begin
      rd_data <= mem[rd_idx];
    end
  end

  assign bus.rd_data_o     = rd_data;
  assign bus.empty_o       = empty;
  assign bus.full_o        = full;
  assign bus.level_o       = level;
  assign bus.almost_full_o = (level >= AF_THR);

`ifdef UART_TX_FIFO_ERR_EN
  logic overflow;
  logic underflow;

  // Error flags ignore flush. The later set overrides the clear so an error
  // arriving in the clear cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.err_clr_i) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (bus.wr_en_i && full)  overflow  <= 1'b1;
      if (bus.rd_en_i && empty) underflow <= 1'b1;
    end
  end

  assign bus.overflow_o  = overflow;
  assign bus.underflow_o = underflow;
`else
  assign bus.overflow_o  = 1'b0;
  assign bus.underflow_o = 1'b0;
`endif

endmodule
